// File: rtl/conv_pkg.sv
// Shared constants and helpers for the rate-1/2 convolutional codec path.
// The Viterbi branch-metric unit reuses oct_to_mask so both ends agree on tap ordering.
package conv_pkg;

  localparam int unsigned DefaultK     = 7;
  localparam logic [15:0] DefaultG0Oct = 16'o171;
  localparam logic [15:0] DefaultG1Oct = 16'o133;

  // Octal digits read as binary; bit i of the result taps r[i], truncated to k bits.
  function automatic logic [15:0] oct_to_mask(input logic [15:0] oct, input int unsigned k);
    logic [15:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < k) begin
        mask[i] = oct[i];
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/conv_encoder_1_2_parity.sv
// One generator branch: AND the register vector with a constant mask and XOR-reduce.
module conv_encoder_1_2_parity #(
  parameter int unsigned K    = 7,
  parameter logic [K-1:0] Mask = '1
) (
  input  logic [K-1:0] r_i,
  output logic         parity_o
);

  assign parity_o = ^(r_i & Mask);

endmodule

// File: rtl/conv_encoder_1_2.sv
// Rate-1/2 feed-forward convolutional encoder with seed-loadable state and a
// registered 2-bit code symbol per accepted information bit.
module conv_encoder_1_2
  import conv_pkg::*;
#(
  parameter int unsigned K      = DefaultK,
  parameter logic [15:0] G0_OCT = DefaultG0Oct,
  parameter logic [15:0] G1_OCT = DefaultG1Oct
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         seed_load_i,
  input  logic [K-2:0] seed_value_i,
  input  logic         in_valid_i,
  input  logic         in_bit_i,
  output logic         out_valid_o,
  output logic [1:0]   out_sym_o
);

  localparam int unsigned M = K - 1;

  localparam logic [15:0]  G0Full = oct_to_mask(G0_OCT, K);
  localparam logic [15:0]  G1Full = oct_to_mask(G1_OCT, K);
  localparam logic [K-1:0] G0Mask = G0Full[K-1:0];
  localparam logic [K-1:0] G1Mask = G1Full[K-1:0];

  logic [M-1:0] st_q, st_d;
  logic [1:0]   sym_q, sym_d;
  logic         valid_q, valid_d;
  logic [K-1:0] r;
  logic         par0, par1;

  // r[K-1] is the current input, st_q[M-1] the newest past bit.
  assign r = {in_bit_i, st_q};

  conv_encoder_1_2_parity #(
    .K    (K),
    .Mask (G0Mask)
  ) u_parity_g0 (
    .r_i      (r),
    .parity_o (par0)
  );

  conv_encoder_1_2_parity #(
    .K    (K),
    .Mask (G1Mask)
  ) u_parity_g1 (
    .r_i      (r),
    .parity_o (par1)
  );

  always_comb begin
    st_d    = st_q;
    sym_d   = sym_q;
    valid_d = 1'b0;
    if (seed_load_i) begin
      st_d = seed_value_i;
    end else if (in_valid_i) begin
      sym_d   = {par0, par1};
      st_d    = {in_bit_i, st_q[M-1:1]};
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q    <= '0;
      sym_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_sym_o   = sym_q;

endmodule

// File: tb/tb_conv_encoder_1_2.sv
// Self-checking bench: K=4 ('o17/'o13) encoder against an input-history model,
// plus a default K=7 instance for the default-parameter cases.
module tb_conv_encoder_1_2;

  localparam int unsigned K4   = 4;
  localparam logic [15:0] G0_4 = 16'o17;
  localparam logic [15:0] G1_4 = 16'o13;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       seed_load = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic [2:0] seed4 = '0;
  logic [5:0] seed7 = '0;
  logic       v4, v7;
  logic [1:0] s4, s7;

  int checks = 0;
  int errors = 0;

  // Model: past[j] is the input accepted j symbols ago.
  bit         past [1:3];
  logic [1:0] exp_sym;
  bit         exp_valid;

  always #5 clk = ~clk;

  conv_encoder_1_2 #(
    .K      (K4),
    .G0_OCT (G0_4),
    .G1_OCT (G1_4)
  ) dut4 (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .seed_load_i  (seed_load),
    .seed_value_i (seed4),
    .in_valid_i   (in_valid),
    .in_bit_i     (in_bit),
    .out_valid_o  (v4),
    .out_sym_o    (s4)
  );

  conv_encoder_1_2 dut7 (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .seed_load_i  (seed_load),
    .seed_value_i (seed7),
    .in_valid_i   (in_valid),
    .in_bit_i     (in_bit),
    .out_valid_o  (v7),
    .out_sym_o    (s7)
  );

  // Tap weight for an input j cycles old is generator bit K-1-j.
  function automatic bit tap_parity(input logic [15:0] g, input bit cur);
    bit acc;
    acc = g[K4-1] & cur;
    for (int j = 1; j <= 3; j++) acc ^= g[K4-1-j] & past[j];
    return acc;
  endfunction

  task automatic model_reset();
    for (int j = 1; j <= 3; j++) past[j] = 1'b0;
    exp_sym   = 2'b00;
    exp_valid = 1'b0;
  endtask

  task automatic model_step(input bit sl, input logic [2:0] sv, input bit v, input bit b);
    if (sl) begin
      for (int j = 1; j <= 3; j++) past[j] = sv[3-j];
      exp_valid = 1'b0;
    end else if (v) begin
      exp_sym = {tap_parity(G0_4, b), tap_parity(G1_4, b)};
      for (int j = 3; j >= 2; j--) past[j] = past[j-1];
      past[1]   = b;
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic drive(input bit sl, input logic [2:0] sv, input bit v, input bit b);
    @(negedge clk);
    seed_load = sl;
    seed4     = sv;
    in_valid  = v;
    in_bit    = b;
    model_step(sl, sv, v, b);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni    = 1'b0;
    in_valid  = 1'b0;
    seed_load = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({v4, s4} !== 3'b000) begin
      errors++;
      $display("FAIL reset_k4 got valid=%b sym=%b want valid=0 sym=00", v4, s4);
    end
    checks++;
    if ({v7, s7} !== 3'b000) begin
      errors++;
      $display("FAIL reset_k7 got valid=%b sym=%b want valid=0 sym=00", v7, s7);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_zeros();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 3'b000, 1'b1, 1'b0);
      checks++;
      if ({v4, s4} !== 3'b100) begin
        errors++;
        $display("FAIL zeros[%0d] got valid=%b sym=%b want valid=1 sym=00", i, v4, s4);
      end
    end
  endtask

  task automatic test_ones();
    logic [1:0] want [6];
    want = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 3'b000, 1'b1, 1'b1);
      checks++;
      if ({v4, s4} !== {1'b1, want[i]} || s4 !== exp_sym) begin
        errors++;
        $display("FAIL ones[%0d] got valid=%b sym=%b want valid=1 sym=%b model=%b",
                 i, v4, s4, want[i], exp_sym);
      end
    end
  endtask

  task automatic test_seed();
    logic [1:0] held;
    do_reset();
    drive(1'b0, 3'b000, 1'b1, 1'b1);
    held = exp_sym;
    drive(1'b1, 3'b101, 1'b1, 1'b1);
    checks++;
    if (v4 !== 1'b0 || s4 !== held) begin
      errors++;
      $display("FAIL seed_cycle got valid=%b sym=%b want valid=0 sym=%b", v4, s4, held);
    end
    drive(1'b0, 3'b000, 1'b1, 1'b0);
    checks++;
    if ({v4, s4} !== 3'b101 || s4 !== exp_sym) begin
      errors++;
      $display("FAIL seed_first got valid=%b sym=%b want valid=1 sym=01", v4, s4);
    end
    // State 010 with input 0 gives r=0010.
    drive(1'b0, 3'b000, 1'b1, 1'b0);
    checks++;
    if ({v4, s4} !== 3'b111 || s4 !== exp_sym) begin
      errors++;
      $display("FAIL seed_state got valid=%b sym=%b want valid=1 sym=11", v4, s4);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 3'b000, 1'b1, 1'($urandom));
      checks++;
      if (v4 !== exp_valid || s4 !== exp_sym) begin
        errors++;
        $display("FAIL b2b[%0d] got valid=%b sym=%b want valid=%b sym=%b",
                 i, v4, s4, exp_valid, exp_sym);
      end
    end
  endtask

  task automatic test_mixed();
    for (int i = 0; i < 80; i++) begin
      drive(($urandom_range(0, 9) == 0), 3'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (v4 !== exp_valid || s4 !== exp_sym) begin
        errors++;
        $display("FAIL mixed[%0d] got valid=%b sym=%b want valid=%b sym=%b",
                 i, v4, s4, exp_valid, exp_sym);
      end
    end
  endtask

  task automatic test_default_k7();
    do_reset();
    drive(1'b0, 3'b000, 1'b1, 1'b1);
    checks++;
    if ({v7, s7} !== 3'b111) begin
      errors++;
      $display("FAIL k7_first got valid=%b sym=%b want valid=1 sym=11", v7, s7);
    end
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    checks++;
    if ({v7, s7} !== 3'b011) begin
      errors++;
      $display("FAIL k7_hold got valid=%b sym=%b want valid=0 sym=11", v7, s7);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b0, 3'b000, 1'b1, 1'($urandom));
    drive(1'b0, 3'b000, 1'b1, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({v4, s4} !== 3'b000 || {v7, s7} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_async got k4 valid=%b sym=%b k7 valid=%b sym=%b want all 0",
               v4, s4, v7, s7);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_ni   = 1'b1;
    model_reset();
    drive(1'b0, 3'b000, 1'b1, 1'b1);
    checks++;
    if ({v4, s4} !== 3'b111) begin
      errors++;
      $display("FAIL midreset_first got valid=%b sym=%b want valid=1 sym=11", v4, s4);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_zeros();
    test_ones();
    test_seed();
    test_back_to_back();
    test_mixed();
    test_default_k7();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
